branch_unit: RTL and testbench
==============================

# branch_unit

Execution stage for control-flow instructions, directly downstream of the branch reservation station. It accepts one ready branch/jump per cycle and evaluates the condition, target and link value in a single registered stage. It broadcasts the result on the Branch CDB and reports the resolution (taken, target) to the ROB. It also owns the branch history table (BHT): trained on every resolved conditional branch, read combinationally by instruction fetch.

## Interface
- XLEN, 32, data/address width
- TAG_W, 4, ROB tag width (matches `TagBus`)
- BHT_IDX_W, 6, log2 of BHT entries (used only with `BRANCH_BHT_EN`)

- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rdy  in  1  global enable; low freezes all state
- clear  in  1  misprediction flush, synchronous
- in_valid  in  1  issue strobe from the reservation station
- in_op  in  `OPBus`  op code (BEQ/BNE/BLT/BGE/BLTU/BGEU/JAL/JALR from cpu_define.v)
- in_reg1, in_reg2  in  XLEN  resolved operands
- in_imm  in  XLEN  sign-extended immediate
- in_pc  in  XLEN  instruction address
- in_rob_tag  in  TAG_W  destination ROB entry
- cdb_valid  out  1  Branch CDB strobe
- cdb_tag  out  TAG_W  ROB tag being completed
- cdb_data  out  XLEN  link value (pc+4) for JAL/JALR; 0 for conditional branches
- rob_br_valid  out  1  resolution strobe (same cycle as cdb_valid)
- rob_br_taken  out  1  1 = control transfers
- rob_br_target  out  XLEN  next PC actually taken (target, or pc+4 if not taken)
- if_pc  in  XLEN  fetch-side lookup address
- if_pred_taken  out  1  combinational prediction for if_pc

## Operation
- Condition: BEQ reg1==reg2; BNE !=; BLT/BGE signed compare; BLTU/BGEU unsigned compare. JAL and JALR are always taken.
- Target:
  - Branches and JAL: pc+imm.
  - JALR: (reg1+imm) & ~1.
  - All sums are modulo 2^XLEN; wrap-around is silent.
- Link: pc+4 modulo 2^XLEN.
- Unrecognised op:
  - Still completes: cdb_valid=1, taken=0, target=pc+4, cdb_data=0.
  - No BHT update.
- BHT (with macro enabled):
  - 2^BHT_IDX_W entries of 2-bit saturating counters, indexed by pc[BHT_IDX_W+1:2].
  - On an accepted conditional branch: taken → increment, saturating at 3; not taken → decrement, saturating at 0.
  - JAL/JALR never update the table.
  - if_pred_taken = counter[if_pc index][1], read combinationally.
  - When a lookup and an update hit the same index in the same cycle, the lookup returns the pre-update value.
- Reset:
  - All outputs 0.
  - Every BHT counter = 2'b01 (weakly not-taken).
- clear:
  - All registered outputs go to 0 on the next edge, and any in_valid that cycle is dropped.
  - The BHT is not modified by clear; history survives flushes.
- rst has priority over clear; clear has priority over in_valid.
- rdy=0: outputs and BHT hold their values and input is ignored. The reservation station holds its own output under rdy=0, so no issue is lost.

## Timing
- Latency is 1 cycle: in_valid sampled at edge N; cdb_* and rob_br_* are valid from edge N through edge N+1.
- Strobes are single-cycle pulses. With in_valid=0 at an edge, the strobes and data return to 0 at that edge.
- Throughput is one instruction per cycle with no backpressure; back-to-back issues produce back-to-back completions.
- The BHT write happens at the same edge as the result register load.
- No state machine: a single pipeline register plus the BHT array.

## Configuration
- `BRANCH_BHT_EN` defined: the BHT is instantiated and trained as above; if_pred_taken reflects counter MSB.
- Not defined:
  - No table storage is synthesised and BHT_IDX_W is unused.
  - if_pred_taken is tied to 0 (static not-taken).
  - All other behaviour is identical.

## Test plan
- BEQ, reg1=reg2=5, pc=0x100, imm=0x20, tag=3 → next cycle cdb_valid=1, cdb_tag=3, cdb_data=0, taken=1, target=0x120. Repeat with reg2=6 → taken=0, target=0x104.
- Signedness: reg1=0xFFFFFFFF, reg2=1. BLT → taken=1; BLTU → taken=0; BGEU → taken=1.
- JALR: reg1=0x2001, imm=0x4, pc=0x40 → taken=1, target=0x2004, cdb_data=0x44. JAL with pc=0xFFFFFFFC, imm=8 → target=0x4 (wrap-around), cdb_data=0x0.
- BHT (macro on):
  - After reset, if_pc=0x100 → pred 0.
  - One taken BEQ at 0x100 → pred 1. Four more taken → counter saturates at 3.
  - Three not-taken → pred 0. A JAL at 0x100 leaves the counter unchanged.
  - Same-cycle lookup/update at 0x100 returns the old value.
- clear: issue BNE taken, assert clear at the same edge → outputs stay 0. Clear while a result is presented → outputs 0 next cycle; BHT value is retained.
- rdy: issue BEQ, drop rdy for 3 cycles → outputs hold the first result unchanged. Raising rdy with in_valid=0 → strobes drop the following cycle.

Source files
------------

// File: rtl/branch_unit.sv
// Branch execution stage: one-cycle condition/target/link evaluation.
// Optional branch history table enabled by `BRANCH_BHT_EN.
module branch_unit #(
  parameter int XLEN      = 32,
  parameter int TAG_W     = 4,
  parameter int BHT_IDX_W = 6,
  parameter int OP_W      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [OP_W-1:0]  in_op,
  input  logic [XLEN-1:0]  in_reg1,
  input  logic [XLEN-1:0]  in_reg2,
  input  logic [XLEN-1:0]  in_imm,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [TAG_W-1:0] in_rob_tag,
  output logic             cdb_valid,
  output logic [TAG_W-1:0] cdb_tag,
  output logic [XLEN-1:0]  cdb_data,
  output logic             rob_br_valid,
  output logic             rob_br_taken,
  output logic [XLEN-1:0]  rob_br_target,
  input  logic [XLEN-1:0]  if_pc,
  output logic             if_pred_taken
);

  localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(1);
  localparam logic [OP_W-1:0] OP_BNE  = OP_W'(2);
  localparam logic [OP_W-1:0] OP_BLT  = OP_W'(3);
  localparam logic [OP_W-1:0] OP_BGE  = OP_W'(4);
  localparam logic [OP_W-1:0] OP_BLTU = OP_W'(5);
  localparam logic [OP_W-1:0] OP_BGEU = OP_W'(6);
  localparam logic [OP_W-1:0] OP_JAL  = OP_W'(7);
  localparam logic [OP_W-1:0] OP_JALR = OP_W'(8);

  logic            w_eq, w_lt, w_ltu;
  logic            w_cond, w_jump, w_jalr, w_taken;
  logic            w_fire;
  logic [XLEN-1:0] w_link, w_pc_tgt, w_jalr_tgt;
  logic [XLEN-1:0] w_target, w_data;

  logic             r_valid;
  logic [TAG_W-1:0] r_tag;
  logic [XLEN-1:0]  r_data;
  logic             r_taken;
  logic [XLEN-1:0]  r_target;

  assign w_eq       = in_reg1 == in_reg2;
  assign w_lt       = $signed(in_reg1) < $signed(in_reg2);
  assign w_ltu      = in_reg1 < in_reg2;
  assign w_link     = in_pc + XLEN'(4);
  assign w_pc_tgt   = in_pc + in_imm;
  assign w_jalr_tgt = (in_reg1 + in_imm) & ~XLEN'(1);
  assign w_fire     = rdy & ~clear & in_valid;

  always_comb begin
    w_cond  = 1'b0;
    w_jump  = 1'b0;
    w_jalr  = 1'b0;
    w_taken = 1'b0;
    unique case (in_op)
      OP_BEQ:  begin w_cond = 1'b1; w_taken = w_eq;   end
      OP_BNE:  begin w_cond = 1'b1; w_taken = ~w_eq;  end
      OP_BLT:  begin w_cond = 1'b1; w_taken = w_lt;   end
      OP_BGE:  begin w_cond = 1'b1; w_taken = ~w_lt;  end
      OP_BLTU: begin w_cond = 1'b1; w_taken = w_ltu;  end
      OP_BGEU: begin w_cond = 1'b1; w_taken = ~w_ltu; end
      OP_JAL:  begin w_jump = 1'b1; w_taken = 1'b1;   end
      OP_JALR: begin
        w_jump  = 1'b1;
        w_jalr  = 1'b1;
        w_taken = 1'b1;
      end
      default: w_taken = 1'b0;
    endcase
  end

  // Not-taken and unknown ops resolve to the fall-through address
  assign w_target = !w_taken ? w_link :
                    w_jalr   ? w_jalr_tgt : w_pc_tgt;
  assign w_data   = w_jump ? w_link : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid  <= 1'b0;
      r_tag    <= '0;
      r_data   <= '0;
      r_taken  <= 1'b0;
      r_target <= '0;
    end else if (rdy) begin
      r_valid  <= w_fire;
      r_tag    <= w_fire ? in_rob_tag : '0;
      r_data   <= w_fire ? w_data : '0;
      r_taken  <= w_fire & w_taken;
      r_target <= w_fire ? w_target : '0;
    end
  end

  assign cdb_valid     = r_valid;
  assign cdb_tag       = r_tag;
  assign cdb_data      = r_data;
  assign rob_br_valid  = r_valid;
  assign rob_br_taken  = r_taken;
  assign rob_br_target = r_target;

  logic w_unused;

`ifdef BRANCH_BHT_EN
  localparam int BHT_N = 1 << BHT_IDX_W;

  logic [1:0]           r_bht [BHT_N];
  logic [BHT_IDX_W-1:0] w_wr_idx, w_rd_idx;
  logic [1:0]           w_ctr;

  assign w_wr_idx = in_pc[BHT_IDX_W+1:2];
  assign w_rd_idx = if_pc[BHT_IDX_W+1:2];
  assign w_ctr    = r_bht[w_wr_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BHT_N; i++)
        r_bht[i] <= 2'b01;
    end else if (w_fire && w_cond) begin
      if (w_taken && w_ctr != 2'b11)
        r_bht[w_wr_idx] <= w_ctr + 2'd1;
      else if (!w_taken && w_ctr != 2'b00)
        r_bht[w_wr_idx] <= w_ctr - 2'd1;
    end
  end

  // Read sees the register, so a same-cycle update is not forwarded
  assign if_pred_taken = r_bht[w_rd_idx][1];
  assign w_unused = ^{if_pc[XLEN-1:BHT_IDX_W+2],
                      if_pc[1:0]};
`else
  assign if_pred_taken = 1'b0;
  assign w_unused = ^{if_pc, w_cond};
`endif

endmodule

// File: tb/tb_branch_unit.sv
// Self-checking bench for branch_unit: directed cases plus a
// randomized run against a behavioural model.
module tb_branch_unit;

  localparam logic [3:0] BEQ  = 4'd1;
  localparam logic [3:0] BNE  = 4'd2;
  localparam logic [3:0] BLT  = 4'd3;
  localparam logic [3:0] BGE  = 4'd4;
  localparam logic [3:0] BLTU = 4'd5;
  localparam logic [3:0] BGEU = 4'd6;
  localparam logic [3:0] JAL  = 4'd7;
  localparam logic [3:0] JALR = 4'd8;
`ifdef BRANCH_BHT_EN
  localparam bit BHT_ON = 1'b1;
`else
  localparam bit BHT_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy = 1'b1;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic [3:0]  in_op = '0;
  logic [31:0] in_reg1 = '0, in_reg2 = '0;
  logic [31:0] in_imm = '0, in_pc = '0;
  logic [3:0]  in_rob_tag = '0;
  logic        cdb_valid, rob_br_valid, rob_br_taken;
  logic [3:0]  cdb_tag;
  logic [31:0] cdb_data, rob_br_target;
  logic [31:0] if_pc = '0;
  logic        if_pred_taken;

  int checks = 0;
  int errors = 0;
  int cnt [64];

  branch_unit dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
    .in_valid(in_valid), .in_op(in_op),
    .in_reg1(in_reg1), .in_reg2(in_reg2),
    .in_imm(in_imm), .in_pc(in_pc),
    .in_rob_tag(in_rob_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .cdb_data(cdb_data), .rob_br_valid(rob_br_valid),
    .rob_br_taken(rob_br_taken),
    .rob_br_target(rob_br_target),
    .if_pc(if_pc), .if_pred_taken(if_pred_taken)
  );

  always #5 clk = ~clk;

  function automatic logic [70:0] outs();
    return {cdb_valid, cdb_tag, cdb_data,
            rob_br_valid, rob_br_taken, rob_br_target};
  endfunction

  // Expected result bundle from the instruction semantics
  function automatic logic [70:0] model(
    logic [3:0] op, logic [31:0] r1, logic [31:0] r2,
    logic [31:0] imm, logic [31:0] pc, logic [3:0] tag);
    longint unsigned m = 64'h1_0000_0000;
    longint unsigned p = pc, i = imm, a = r1;
    longint unsigned link, tgt;
    int sa = r1, sb = r2;
    bit tk = 0, jmp = 0;
    case (op)
      BEQ:  tk = r1 == r2;
      BNE:  tk = r1 != r2;
      BLT:  tk = sa < sb;
      BGE:  tk = sa >= sb;
      BLTU: tk = r1 < r2;
      BGEU: tk = r1 >= r2;
      JAL, JALR: begin tk = 1; jmp = 1; end
      default: tk = 0;
    endcase
    link = (p + 4) % m;
    if (!tk) tgt = link;
    else if (op == JALR) tgt = ((a + i) % m) / 2 * 2;
    else tgt = (p + i) % m;
    return {1'b1, tag, jmp ? link[31:0] : 32'd0,
            1'b1, tk, tgt[31:0]};
  endfunction

  function automatic bit pred_of(logic [31:0] a);
    return BHT_ON && cnt[a[7:2]] >= 2;
  endfunction

  task automatic drive(bit v, logic [3:0] op,
    logic [31:0] r1, logic [31:0] r2, logic [31:0] imm,
    logic [31:0] pc, logic [3:0] tag);
    in_valid = v; in_op = op; in_reg1 = r1; in_reg2 = r2;
    in_imm = imm; in_pc = pc; in_rob_tag = tag;
  endtask

  // Clock edge plus history-table model update
  task automatic tick();
    logic [70:0] r;
    @(posedge clk);
    if (rst) begin
      foreach (cnt[k]) cnt[k] = 1;
    end else if (rdy && !clear && in_valid
                 && in_op >= BEQ && in_op <= BGEU) begin
      r = model(in_op, in_reg1, in_reg2, in_imm, in_pc, 0);
      if (r[32]) cnt[in_pc[7:2]] = (cnt[in_pc[7:2]] == 3) ?
                                   3 : cnt[in_pc[7:2]] + 1;
      else cnt[in_pc[7:2]] = (cnt[in_pc[7:2]] == 0) ?
                             0 : cnt[in_pc[7:2]] - 1;
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1; clear = 1; rdy = 1;
    drive(1, BEQ, 5, 5, 32'h20, 32'h100, 3);
    tick(); tick();
    checks++;
    if (outs() !== '0) begin
      errors++;
      $display("FAIL reset_outs got %h want 0", outs());
    end
    if_pc = 32'h100; #1;
    checks++;
    if (if_pred_taken !== 1'b0) begin
      errors++;
      $display("FAIL reset_pred got %b want 0", if_pred_taken);
    end
    rst = 0; clear = 0; in_valid = 0;
    tick();
    checks++;
    if (outs() !== '0) begin
      errors++;
      $display("FAIL idle_outs got %h want 0", outs());
    end
  endtask

  task automatic test_bht();
    if_pc = 32'h100;
    for (int n = 0; n < 8; n++) begin
      if (n < 5) drive(1, BEQ, 5, 5, 32'h20, 32'h100, 1);
      else drive(1, BEQ, 5, 6, 32'h20, 32'h100, 1);
      tick();
      checks++;
      if (if_pred_taken !== pred_of(32'h100)) begin
        errors++;
        $display("FAIL bht_train%0d got %b want %b", n,
                 if_pred_taken, pred_of(32'h100));
      end
    end
    checks++;
    if (if_pred_taken !== 1'b0) begin
      errors++;
      $display("FAIL bht_nt got %b want 0", if_pred_taken);
    end
    drive(1, JAL, 0, 0, 32'h8, 32'h100, 2);
    tick();
    drive(1, BEQ, 5, 5, 32'h20, 32'h100, 3);
    tick();
    checks++;
    if (if_pred_taken !== 1'b0) begin
      errors++;
      $display("FAIL bht_jal got %b want 0", if_pred_taken);
    end
    drive(1, BEQ, 5, 5, 32'h20, 32'h100, 4);
    #1;
    checks++;
    if (if_pred_taken !== 1'b0) begin
      errors++;
      $display("FAIL bht_same_old got %b want 0",
               if_pred_taken);
    end
    tick();
    checks++;
    if (if_pred_taken !== BHT_ON) begin
      errors++;
      $display("FAIL bht_same_new got %b want %b",
               if_pred_taken, BHT_ON);
    end
    in_valid = 0;
    tick();
  endtask

  task automatic test_cond();
    drive(1, BEQ, 5, 5, 32'h20, 32'h100, 3);
    tick();
    checks++;
    if (outs() !== {1'b1, 4'd3, 32'd0, 1'b1, 1'b1, 32'h120})
    begin
      errors++;
      $display("FAIL beq_taken got %h", outs());
    end
    drive(1, BEQ, 5, 6, 32'h20, 32'h100, 3);
    tick();
    checks++;
    if (outs() !== {1'b1, 4'd3, 32'd0, 1'b1, 1'b0, 32'h104})
    begin
      errors++;
      $display("FAIL beq_not got %h", outs());
    end
    in_valid = 0;
    tick();
    checks++;
    if (outs() !== '0) begin
      errors++;
      $display("FAIL strobe_drop got %h want 0", outs());
    end
  endtask

  task automatic test_signed();
    logic [3:0] ops [4] = '{BLT, BLTU, BGEU, BGE};
    logic [31:0] tg [4] = '{32'h340, 32'h304, 32'h340, 32'h304};
    bit tk [4] = '{1, 0, 1, 0};
    for (int n = 0; n < 4; n++) begin
      drive(1, ops[n], 32'hFFFF_FFFF, 1, 32'h40, 32'h300, 5);
      tick();
      checks++;
      if (outs() !== {1'b1, 4'd5, 32'd0, 1'b1, tk[n], tg[n]})
      begin
        errors++;
        $display("FAIL signed_op%0d got %h", ops[n], outs());
      end
    end
  endtask

  task automatic test_jump();
    drive(1, JALR, 32'h2001, 0, 32'h4, 32'h40, 7);
    tick();
    checks++;
    if (outs() !== {1'b1, 4'd7, 32'h44, 1'b1, 1'b1, 32'h2004})
    begin
      errors++;
      $display("FAIL jalr got %h", outs());
    end
    drive(1, JAL, 0, 0, 32'h8, 32'hFFFF_FFFC, 8);
    tick();
    checks++;
    if (outs() !== {1'b1, 4'd8, 32'h0, 1'b1, 1'b1, 32'h4})
    begin
      errors++;
      $display("FAIL jal_wrap got %h", outs());
    end
    drive(1, 4'd0, 3, 3, 32'h8, 32'h10, 9);
    tick();
    checks++;
    if (outs() !== {1'b1, 4'd9, 32'h0, 1'b1, 1'b0, 32'h14})
    begin
      errors++;
      $display("FAIL unknown_op got %h", outs());
    end
  endtask

  task automatic test_clear();
    if_pc = 32'h200;
    clear = 1;
    drive(1, BNE, 1, 2, 32'h10, 32'h200, 2);
    tick();
    checks++;
    if (outs() !== '0 || if_pred_taken !== pred_of(32'h200))
    begin
      errors++;
      $display("FAIL clear_issue got %h/%b want 0/%b", outs(),
               if_pred_taken, pred_of(32'h200));
    end
    clear = 0;
    drive(1, BEQ, 9, 9, 32'h10, 32'h200, 4);
    tick();
    checks++;
    if (outs() !== {1'b1, 4'd4, 32'd0, 1'b1, 1'b1, 32'h210})
    begin
      errors++;
      $display("FAIL pre_clear got %h", outs());
    end
    clear = 1;
    drive(1, BEQ, 9, 9, 32'h10, 32'h200, 6);
    tick();
    checks++;
    if (outs() !== '0 || if_pred_taken !== pred_of(32'h200))
    begin
      errors++;
      $display("FAIL clear_result got %h/%b want 0/%b", outs(),
               if_pred_taken, pred_of(32'h200));
    end
    clear = 0; in_valid = 0;
  endtask

  task automatic test_rdy();
    logic [70:0] e = {1'b1, 4'd9, 32'd0, 1'b1, 1'b1, 32'h180};
    drive(1, BEQ, 7, 7, 32'h100, 32'h80, 9);
    tick();
    rdy = 0;
    drive(1, BNE, 1, 2, 32'h4, 32'h84, 10);
    for (int n = 0; n < 3; n++) begin
      tick();
      checks++;
      if (outs() !== e) begin
        errors++;
        $display("FAIL rdy_hold%0d got %h want %h", n, outs(), e);
      end
    end
    rdy = 1; in_valid = 0;
    tick();
    checks++;
    if (outs() !== '0) begin
      errors++;
      $display("FAIL rdy_release got %h want 0", outs());
    end
  endtask

  task automatic test_back_to_back();
    logic [70:0] e;
    for (int n = 0; n < 6; n++) begin
      drive(1, 4'(1 + n), $urandom_range(0, 3),
            $urandom_range(0, 3), 32'h30, 32'h400 + 4 * n,
            4'(n));
      e = model(in_op, in_reg1, in_reg2, in_imm, in_pc,
                in_rob_tag);
      tick();
      checks++;
      if (outs() !== e) begin
        errors++;
        $display("FAIL b2b%0d got %h want %h", n, outs(), e);
      end
    end
    in_valid = 0;
    tick();
  endtask

  task automatic test_random();
    logic [70:0] ev = '0;
    logic [31:0] r1, pc;
    for (int n = 0; n < 400; n++) begin
      r1 = $urandom;
      pc = ($urandom_range(0, 9) == 0) ? $urandom
                                       : ($urandom & 32'h3FC);
      drive($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)),
            r1, ($urandom_range(0, 2) == 0) ? r1 : $urandom,
            $urandom, pc, 4'($urandom));
      rdy = $urandom_range(0, 9) != 0;
      clear = $urandom_range(0, 9) == 0;
      if_pc = ($urandom_range(0, 1) == 0) ? pc
                                          : ($urandom & 32'hFC);
      #1;
      checks++;
      if (if_pred_taken !== pred_of(if_pc)) begin
        errors++;
        $display("FAIL rnd_pred%0d got %b want %b", n,
                 if_pred_taken, pred_of(if_pc));
      end
      if (rdy) ev = (clear || !in_valid) ? '0 :
        model(in_op, in_reg1, in_reg2, in_imm, in_pc, in_rob_tag);
      tick();
      checks++;
      if (outs() !== ev) begin
        errors++;
        $display("FAIL rnd_out%0d got %h want %h", n, outs(), ev);
      end
    end
    rdy = 1; clear = 0; in_valid = 0;
  endtask

  initial begin
    test_reset();
    test_bht();
    test_cond();
    test_signed();
    test_jump();
    test_clear();
    test_rdy();
    test_back_to_back();
    test_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
